// File: rtl/oam_dma_pkg.sv
// Shared PPU defines: register indices, the DMA trigger address and the OAM DMA state encoding.
package oam_dma_pkg;

  localparam logic [2:0]  OAMDATA_IDX  = 3'h4;
  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: copies one CPU page into PPU OAMDATA, halting the CPU for 1+2*OAM_BYTES CPU cycles (+1 to align).
// All state advances on cpu_ce edges; outputs are decoded from state and registers.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int         OAM_BYTES   = 256,
  parameter logic [2:0] OAMDATA_REG = OAMDATA_IDX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic        reg_wr,
  input  logic [7:0]  reg_data,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  input  logic [7:0]  bus_data_i,
  output logic        ppu_cs,
  output logic        ppu_rw,
  output logic [2:0]  ppu_addr,
  output logic [7:0]  ppu_data,
  output logic        done
);

  localparam logic [7:0] IDX_LAST = 8'(OAM_BYTES - 1);

  dma_state_t state, state_nxt;
  logic       p;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic       done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (cpu_ce) begin
      state <= state_nxt;
    end
  end

  // p here is the pre-toggle value; the post-HALT parity is its inverse.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (reg_wr) state_nxt = ST_HALT;
      ST_HALT:  state_nxt = p ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = (idx == IDX_LAST) ? ST_IDLE : ST_READ;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
      data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cpu_ce) begin
        p <= ~p;
        case (state)
          ST_IDLE: begin
            if (reg_wr) begin
              page <= reg_data;
              idx  <= 8'h00;
            end
          end
          ST_READ:  data_q <= bus_data_i;
          ST_WRITE: begin
            idx    <= (idx + 8'd1) & IDX_LAST;
            done_q <= (idx == IDX_LAST);
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_rdy    = (state == ST_IDLE);
  assign dma_active = (state != ST_IDLE);
  assign bus_rd     = (state == ST_READ);
  assign bus_addr   = (state == ST_READ) ? {page, idx} : 16'h0000;
  assign ppu_cs     = (state == ST_WRITE);
  assign ppu_rw     = (state != ST_WRITE);
  assign ppu_addr   = (state == ST_WRITE) ? OAMDATA_REG : 3'd0;
  assign ppu_data   = (state == ST_WRITE) ? data_q : 8'h00;
  assign done       = done_q;

endmodule
